// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a byte-wide register bus, shadowed duty/control,
// edge- or center-aligned counting and LFSR dither added to the compare threshold.
module pwm_multi #(
  parameter int PWM_BITS = 10,
  parameter int CHANNELS = 4
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [7:0]          b_addr_i,
  input  logic [7:0]          b_data_i,
  output logic [7:0]          b_data_o,
  input  logic [1:0]          b_event_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                irq_o
);

  localparam logic [PWM_BITS-1:0] MAX_CNT = '1;
  localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
  localparam logic [0:0]          DIR_UP   = 1'b0;
  localparam logic [0:0]          DIR_DOWN = 1'b1;

  logic                en, mode, irq_en, status;
  logic [1:0]          ss;
  logic [PWM_BITS-1:0] counter;
  logic [0:0]          dir;
  logic [7:0]          lfsr;
  logic [7:0]          dither;
  logic [PWM_BITS:0]   dither_ext;

  logic [PWM_BITS-1:0] sh_duty   [CHANNELS];
  logic [PWM_BITS-1:0] act_duty  [CHANNELS];
  logic [1:0]          sh_chctl  [CHANNELS];
  logic [1:0]          act_chctl [CHANNELS];
  logic [CHANNELS-1:0] raw;

  logic       wr, ctl0_wr, status_wr, ch_hit;
  logic [7:0] ch_off;
  logic       en_rise, mode_chg, restart, at_wrap, boundary, load_active, fb;
  logic [15:0] rd_ext;
  logic       unused_rd_strobe;

  // Duty registers are handled through a 16-bit view so PWM_BITS=8 needs no special case
  function automatic logic [PWM_BITS-1:0] with_lo(input logic [PWM_BITS-1:0] cur,
                                                  input logic [7:0] d);
    logic [15:0] t;
    t = 16'(cur);
    t[7:0] = d;
    return t[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] with_hi(input logic [PWM_BITS-1:0] cur,
                                                  input logic [7:0] d);
    logic [15:0] t;
    t = 16'(cur);
    t[15:8] = d;
    return t[PWM_BITS-1:0];
  endfunction

  assign unused_rd_strobe = b_event_i[0];
  assign wr        = b_event_i[1];
  assign ctl0_wr   = wr && (b_addr_i == 8'h00);
  assign status_wr = wr && (b_addr_i == 8'h01);
  assign ch_off    = b_addr_i - 8'h10;
  assign ch_hit    = (b_addr_i >= 8'h10) && ({2'b00, ch_off[7:2]} < 8'(CHANNELS));

  // A disable, a fresh enable or a mode switch all restart the count without a boundary
  assign en_rise  = ctl0_wr && b_data_i[7] && !en;
  assign mode_chg = ctl0_wr && b_data_i[7] && en && (b_data_i[6] != mode);
  assign restart  = ctl0_wr && (!b_data_i[7] || en_rise || mode_chg);
  assign at_wrap  = mode ? ((dir == DIR_DOWN) && (counter == ONE)) : (counter == MAX_CNT);
  assign boundary    = en && at_wrap && !restart;
  assign load_active = boundary || en_rise;
  assign fb          = lfsr[7];
  assign irq_o       = status && irq_en;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      en     <= 1'b0;
      mode   <= 1'b0;
      irq_en <= 1'b0;
      ss     <= 2'b00;
    end else if (ctl0_wr) begin
      en     <= b_data_i[7];
      mode   <= b_data_i[6];
      irq_en <= b_data_i[5];
      ss     <= b_data_i[1:0];
    end
  end

  // A boundary wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      status <= 1'b0;
    end else if (boundary) begin
      status <= 1'b1;
    end else if (status_wr && b_data_i[0]) begin
      status <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lfsr <= 8'hFF;
    end else if (boundary) begin
      lfsr <= {lfsr[6:4], lfsr[3] ^ fb, lfsr[2] ^ fb, lfsr[1] ^ fb, lfsr[0], fb};
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      counter <= '0;
      dir     <= DIR_UP;
    end else if (restart) begin
      counter <= '0;
      dir     <= DIR_UP;
    end else if (en) begin
      if (!mode) begin
        counter <= counter + ONE;
        dir     <= DIR_UP;
      end else if (dir == DIR_UP) begin
        if (counter == MAX_CNT) begin
          counter <= MAX_CNT - ONE;
          dir     <= DIR_DOWN;
        end else begin
          counter <= counter + ONE;
        end
      end else begin
        counter <= counter - ONE;
        if (counter == ONE) begin
          dir <= DIR_UP;
        end
      end
    end
  end

  // Active copies take the pre-write shadow values, so a write on a boundary lands next period
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int n = 0; n < CHANNELS; n++) begin
        sh_duty[n]   <= '0;
        act_duty[n]  <= '0;
        sh_chctl[n]  <= 2'b00;
        act_chctl[n] <= 2'b00;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (load_active) begin
          act_duty[n]  <= sh_duty[n];
          act_chctl[n] <= sh_chctl[n];
        end
        if (wr && ch_hit && (ch_off[7:2] == 6'(n))) begin
          case (ch_off[1:0])
            2'd0:    sh_duty[n]  <= with_lo(sh_duty[n], b_data_i);
            2'd1:    sh_duty[n]  <= with_hi(sh_duty[n], b_data_i);
            2'd2:    sh_chctl[n] <= b_data_i[1:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    case (ss)
      2'd1:    dither = {6'b000000, lfsr[7:6]};
      2'd2:    dither = {4'b0000, lfsr[7:4]};
      2'd3:    dither = {2'b00, lfsr[7:2]};
      default: dither = 8'h00;
    endcase
    dither_ext = {{(PWM_BITS-7){1'b0}}, dither};
  end

  // Threshold is one bit wider than the counter so duty+dither never wraps
  always_comb begin
    raw = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      raw[n] = ({1'b0, counter} < ({1'b0, act_duty[n]} + dither_ext)) && act_chctl[n][0];
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pwm_o <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_o[n] <= en ? (raw[n] ^ act_chctl[n][1]) : sh_chctl[n][1];
      end
    end
  end

  always_comb begin
    b_data_o = 8'h00;
    rd_ext   = 16'h0000;
    if (b_addr_i == 8'h00) begin
      b_data_o = {en, mode, irq_en, 3'b000, ss};
    end else if (b_addr_i == 8'h01) begin
      b_data_o = {7'b0000000, status};
    end else if (ch_hit) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_off[7:2] == 6'(n)) begin
          rd_ext = 16'(sh_duty[n]);
          case (ch_off[1:0])
            2'd0:    b_data_o = rd_ext[7:0];
            2'd1:    b_data_o = rd_ext[15:8];
            2'd2:    b_data_o = {6'b000000, sh_chctl[n]};
            default: b_data_o = 8'h00;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a phase-based reference model checked every cycle, plus
// directed scenarios with hand-computed pulse widths, interrupt timing and readbacks.
module tb_pwm_multi;

  localparam int PWM_BITS = 10;
  localparam int CHANNELS = 4;
  localparam int MAXV     = (1 << PWM_BITS) - 1;

  logic                clk_i = 1'b0;
  logic                nrst_i = 1'b0;
  logic [7:0]          b_addr_i = 8'h00;
  logic [7:0]          b_data_i = 8'h00;
  logic [1:0]          b_event_i = 2'b00;
  logic [7:0]          b_data_o;
  logic [CHANNELS-1:0] pwm_o;
  logic                irq_o;

  int checks = 0;
  int errors = 0;
  int hi_acc = 0;
  int nprint = 0;
  bit chk_on = 1'b0;

  // Reference model state: position within the period instead of a counter/direction pair
  bit                  m_en, m_mode, m_irqen, m_status;
  int                  m_ss, m_lfsr, m_phase;
  int                  m_sh_duty [CHANNELS];
  int                  m_act_duty[CHANNELS];
  int                  m_sh_ctl  [CHANNELS];
  int                  m_act_ctl [CHANNELS];
  logic [CHANNELS-1:0] m_pwm;

  pwm_multi #(.PWM_BITS(PWM_BITS), .CHANNELS(CHANNELS)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .b_data_o(b_data_o), .b_event_i(b_event_i), .pwm_o(pwm_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int lfsr_next(input int q);
    int r;
    r = q << 1;
    if ((r & 256) != 0) r = (r & 255) ^ 8'h1D;
    return r;
  endfunction

  function automatic int period_of(input bit mode);
    return mode ? 2 * MAXV : MAXV + 1;
  endfunction

  function automatic int count_at(input int phase, input bit mode);
    if (!mode || phase <= MAXV) return phase;
    return 2 * MAXV - phase;
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_irqen = 0; m_status = 0;
    m_ss = 0; m_lfsr = 8'hFF; m_phase = 0; m_pwm = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      m_sh_duty[c] = 0; m_act_duty[c] = 0; m_sh_ctl[c] = 0; m_act_ctl[c] = 0;
    end
  endtask

  task automatic model_step();
    int cnt, dith, off, ch, d;
    bit wr, ctl_wr, rise, mchg, restart, bnd;
    cnt  = count_at(m_phase, m_mode);
    dith = (m_ss == 0) ? 0 : (m_lfsr >> (8 - 2 * m_ss));
    for (int c = 0; c < CHANNELS; c++) begin
      if (m_en) m_pwm[c] = ((cnt < m_act_duty[c] + dith) && ((m_act_ctl[c] & 1) != 0))
                           ^ ((m_act_ctl[c] & 2) != 0);
      else      m_pwm[c] = (m_sh_ctl[c] & 2) != 0;
    end
    wr      = b_event_i[1];
    d       = int'(b_data_i);
    ctl_wr  = wr && (b_addr_i == 8'h00);
    rise    = ctl_wr && b_data_i[7] && !m_en;
    mchg    = ctl_wr && b_data_i[7] && m_en && (b_data_i[6] != m_mode);
    restart = ctl_wr && (!b_data_i[7] || rise || mchg);
    bnd     = m_en && !restart && (m_phase == period_of(m_mode) - 1);
    if (restart)   m_phase = 0;
    else if (m_en) m_phase = (m_phase + 1) % period_of(m_mode);
    if (bnd || rise) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_act_duty[c] = m_sh_duty[c];
        m_act_ctl[c]  = m_sh_ctl[c];
      end
    end
    if (bnd) begin
      m_lfsr   = lfsr_next(m_lfsr);
      m_status = 1;
    end else if (wr && b_addr_i == 8'h01 && b_data_i[0]) begin
      m_status = 0;
    end
    if (ctl_wr) begin
      m_en = b_data_i[7]; m_mode = b_data_i[6]; m_irqen = b_data_i[5]; m_ss = d & 3;
    end
    if (wr && b_addr_i >= 8'h10) begin
      off = d - d + int'(b_addr_i) - 16;
      ch  = off / 4;
      if (ch < CHANNELS) begin
        case (off % 4)
          0: m_sh_duty[ch] = (m_sh_duty[ch] & ~255) | d;
          1: m_sh_duty[ch] = ((d * 256) | (m_sh_duty[ch] & 255)) & MAXV;
          2: m_sh_ctl[ch]  = d & 3;
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) model_reset();
    else         model_step();
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      checks++;
      if (pwm_o !== m_pwm) begin
        errors++;
        if (nprint < 10) $display("[TB] FAIL pwm_cycle t=%0t actual=%b required=%b", $time, pwm_o, m_pwm);
        nprint++;
      end
      checks++;
      if (irq_o !== (m_status && m_irqen)) begin
        errors++;
        if (nprint < 10) $display("[TB] FAIL irq_cycle t=%0t actual=%b required=%b", $time, irq_o, m_status && m_irqen);
        nprint++;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    hi_acc += int'(pwm_o[0]);
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    b_addr_i  = addr;
    b_data_i  = data;
    b_event_i = 2'b10;
    tick();
    b_event_i = 2'b00;
  endtask

  task automatic checkValue(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] addr, input logic [7:0] required);
    b_addr_i  = addr;
    b_event_i = 2'b01;
    #1;
    checks++;
    if (b_data_o !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%02h required=0x%02h", name, b_data_o, required);
    end
    b_event_i = 2'b00;
  endtask

  task automatic measure(input int n);
    hi_acc = 0;
    repeat (n) tick();
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    chk_on = 1'b1;

    $display("[TB] reset state and register map");
    checkValue("rst_pwm", int'(pwm_o), 0);
    checkValue("rst_irq", int'(irq_o), 0);
    checkOutput("rst_ctl0", 8'h00, 8'h00);
    checkOutput("rst_status", 8'h01, 8'h00);
    checkOutput("rst_lfsr_free_lo", 8'h10, 8'h00);
    applyStimulus(8'h11, 8'hFF);
    checkOutput("duty_hi_mask", 8'h11, 8'h03);
    applyStimulus(8'h00, 8'h1C);
    checkOutput("ctl0_unimpl", 8'h00, 8'h00);
    applyStimulus(8'h20, 8'hFF);
    checkOutput("absent_channel", 8'h20, 8'h00);
    checkOutput("unmapped_offset3", 8'h13, 8'h00);
    checkOutput("unmapped_low", 8'h05, 8'h00);
    applyStimulus(8'h10, 8'h00);
    applyStimulus(8'h11, 8'h01);
    applyStimulus(8'h12, 8'h01);
    checkOutput("chctl0_rb", 8'h12, 8'h01);
    checkOutput("duty_hi0_rb", 8'h11, 8'h01);

    $display("[TB] edge mode, duty 0x100, then mid-period rewrite to 0x200");
    applyStimulus(8'h00, 8'h80);
    checkOutput("ctl0_en_rb", 8'h00, 8'h80);
    checkValue("pwm_before_first", int'(pwm_o[0]), 0);
    hi_acc = 0;
    tick();
    checkValue("pwm_first_high", int'(pwm_o[0]), 1);
    repeat (1023) tick();
    checkValue("edge_period1_high", hi_acc, 256);
    hi_acc = 0;
    repeat (100) tick();
    applyStimulus(8'h11, 8'h02);
    repeat (923) tick();
    checkValue("edge_period2_high", hi_acc, 256);
    measure(1024);
    checkValue("edge_period3_high", hi_acc, 512);

    $display("[TB] center mode, duty 0x100");
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h11, 8'h01);
    applyStimulus(8'h00, 8'hC0);
    checkValue("center_pre_first", int'(pwm_o[0]), 0);
    // counter values 0..255 rising and 255..1 falling are below the threshold
    measure(2046);
    checkValue("center_period1_high", hi_acc, 511);
    measure(2046);
    checkValue("center_period2_high", hi_acc, 511);

    $display("[TB] interrupt and status clear");
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h01, 8'h01);
    checkOutput("status_cleared", 8'h01, 8'h00);
    applyStimulus(8'h00, 8'hA0);
    repeat (1023) tick();
    checkValue("irq_before_boundary", int'(irq_o), 0);
    tick();
    checkValue("irq_at_boundary", int'(irq_o), 1);
    repeat (1023) tick();
    applyStimulus(8'h01, 8'h01);
    checkValue("irq_clear_on_boundary", int'(irq_o), 1);
    applyStimulus(8'h01, 8'h01);
    checkValue("irq_cleared", int'(irq_o), 0);
    checkOutput("status_after_clear", 8'h01, 8'h00);

    $display("[TB] invert while disabled, reset mid-period");
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h16, 8'h02);
    tick();
    checkValue("invert_disabled", int'(pwm_o), 2);
    applyStimulus(8'h00, 8'h80);
    repeat (300) tick();
    #2 nrst_i = 1'b0;
    #1;
    checkValue("reset_pwm", int'(pwm_o), 0);
    checkValue("reset_irq", int'(irq_o), 0);
    checkOutput("reset_ctl0", 8'h00, 8'h00);
    checkOutput("reset_duty_hi0", 8'h11, 8'h00);
    checkOutput("reset_chctl1", 8'h16, 8'h00);
    @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (20) tick();
    checkValue("idle_after_reset", int'(pwm_o), 0);

    $display("[TB] dither SS=3 from fresh LFSR, then SS=0");
    applyStimulus(8'h12, 8'h01);
    applyStimulus(8'h00, 8'h83);
    measure(1024);
    checkValue("dither_p1_lfsr_ff", hi_acc, 63);
    measure(1024);
    checkValue("dither_p2_lfsr_e3", hi_acc, 56);
    measure(1024);
    checkValue("dither_p3_lfsr_db", hi_acc, 54);
    applyStimulus(8'h00, 8'h80);
    tick();
    measure(1024);
    checkValue("ss0_duty0_low", hi_acc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
